// File: rtl/byteswap_axi_write_ctrl.sv
// AXI4 write master for the byteswap kernel: splits a byte count into INCR bursts,
// passes the swapped stream onto W, and limits in-flight bursts by B-response credit.
module byteswap_axi_write_ctrl #(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_DATA_WIDTH      = 512,
    parameter int C_XFER_SIZE_WIDTH = 32,
    parameter int C_BURST_LEN       = 64,
    parameter int C_MAX_OUTSTANDING = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ctrl_start,
    output logic                          ctrl_done,
    input  logic [C_ADDR_WIDTH-1:0]       ctrl_addr_offset,
    input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [C_ADDR_WIDTH-1:0]       m_axi_awaddr,
    output logic [7:0]                    m_axi_awlen,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    output logic [C_DATA_WIDTH-1:0]       m_axi_wdata,
    output logic [C_DATA_WIDTH/8-1:0]     m_axi_wstrb,
    output logic                          m_axi_wlast,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [C_DATA_WIDTH-1:0]       s_axis_tdata
);

    localparam int XW         = C_XFER_SIZE_WIDTH;
    localparam int BPB        = C_DATA_WIDTH / 8;
    localparam int BEAT_SHIFT = $clog2(BPB);
    localparam int OW         = $clog2(C_MAX_OUTSTANDING + 1);

    localparam logic [C_ADDR_WIDTH-1:0] BURST_BYTES = C_ADDR_WIDTH'(C_BURST_LEN * BPB);
    localparam logic [7:0]              FULL_LEN_M1 = 8'(C_BURST_LEN - 1);
    localparam logic [OW-1:0]           MAX_OUT     = OW'(C_MAX_OUTSTANDING);
    localparam logic [XW-1:0]           ONE         = XW'(1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_next;

    logic [XW-1:0]           total_beats, full_bursts, rem_beats, num_bursts;
    logic [7:0]              last_len_m1;
    logic [C_ADDR_WIDTH-1:0] aw_addr;
    logic [XW-1:0]           aw_left, w_left, b_left;
    logic [7:0]              last_len, beat, cur_len_m1;
    logic [OW-1:0]           outstanding, w_credit;
    logic                    w_open, aw_hs, w_hs, wlast_hs, b_hs, b_all, w_all;

    // Burst split of the requested size, evaluated only when a start is taken
    always_comb begin
        total_beats = ctrl_xfer_size_in_bytes >> BEAT_SHIFT;
        full_bursts = total_beats / XW'(C_BURST_LEN);
        rem_beats   = total_beats % XW'(C_BURST_LEN);
        num_bursts  = full_bursts + XW'(rem_beats != '0);
        last_len_m1 = (rem_beats != '0) ? rem_beats[7:0] - 8'd1 : FULL_LEN_M1;
    end

    assign m_axi_awvalid = (state == BUSY) && (aw_left != '0) && (outstanding < MAX_OUT);
    assign m_axi_awaddr  = aw_addr;
    assign m_axi_awlen   = (aw_left == ONE) ? last_len : FULL_LEN_M1;

    // W may only carry bursts whose address has already been accepted
    assign w_open        = (state == BUSY) && (w_credit != '0);
    assign cur_len_m1    = (w_left == ONE) ? last_len : FULL_LEN_M1;
    assign m_axi_wvalid  = w_open && s_axis_tvalid;
    assign s_axis_tready = w_open && m_axi_wready;
    assign m_axi_wdata   = s_axis_tdata;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = w_open && (beat == cur_len_m1);
    assign m_axi_bready  = (state == BUSY);
    assign ctrl_done     = (state == DONE);

    assign aw_hs    = m_axi_awvalid && m_axi_awready;
    assign w_hs     = m_axi_wvalid && m_axi_wready;
    assign wlast_hs = w_hs && m_axi_wlast;
    assign b_hs     = m_axi_bvalid && m_axi_bready;
    assign b_all    = (b_left == '0) || ((b_left == ONE) && b_hs);
    assign w_all    = (w_left == '0) || ((w_left == ONE) && wlast_hs);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ctrl_start) state_next = (total_beats == '0) ? DONE : BUSY;
            BUSY:    if (b_all && w_all) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_addr     <= '0;
            aw_left     <= '0;
            w_left      <= '0;
            b_left      <= '0;
            last_len    <= '0;
            beat        <= '0;
            outstanding <= '0;
            w_credit    <= '0;
        end else if (state == IDLE && ctrl_start) begin
            aw_addr     <= ctrl_addr_offset;
            aw_left     <= num_bursts;
            w_left      <= num_bursts;
            b_left      <= num_bursts;
            last_len    <= last_len_m1;
            beat        <= '0;
            outstanding <= '0;
            w_credit    <= '0;
        end else begin
            if (aw_hs) begin
                aw_addr <= aw_addr + BURST_BYTES;
                aw_left <= aw_left - ONE;
            end
            if (aw_hs && !b_hs)
                outstanding <= outstanding + OW'(1);
            else if (!aw_hs && b_hs && outstanding != '0)
                outstanding <= outstanding - OW'(1);
            if (aw_hs && !wlast_hs)
                w_credit <= w_credit + OW'(1);
            else if (!aw_hs && wlast_hs)
                w_credit <= w_credit - OW'(1);
            if (w_hs)
                beat <= m_axi_wlast ? 8'd0 : beat + 8'd1;
            if (wlast_hs)
                w_left <= w_left - ONE;
            if (b_hs && b_left != '0)
                b_left <= b_left - ONE;
        end
    end

endmodule

// File: tb/tb_byteswap_axi_write_ctrl.sv
// Bench for byteswap_axi_write_ctrl: randomized AXI slave/stream source, a burst-split
// reference model, a vector table of transfers and hand-built corner sequences.
module tb_byteswap_axi_write_ctrl;

    localparam int AW = 64, DW = 512, XW = 32, BL = 64, MO = 2, BPB = DW / 8;

    logic          clk = 1'b0;
    logic          rst, ctrl_start, ctrl_done;
    logic [AW-1:0] ctrl_addr_offset, m_axi_awaddr;
    logic [XW-1:0] ctrl_xfer_size_in_bytes;
    logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_wlast;
    logic [7:0]    m_axi_awlen;
    logic [DW-1:0] m_axi_wdata, s_axis_tdata;
    logic [BPB-1:0] m_axi_wstrb;
    logic          m_axi_bvalid, m_axi_bready, s_axis_tvalid, s_axis_tready;

    byteswap_axi_write_ctrl #(
        .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_XFER_SIZE_WIDTH(XW),
        .C_BURST_LEN(BL), .C_MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst), .ctrl_start(ctrl_start), .ctrl_done(ctrl_done),
        .ctrl_addr_offset(ctrl_addr_offset), .ctrl_xfer_size_in_bytes(ctrl_xfer_size_in_bytes),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
        .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed { logic [AW-1:0] addr; logic [7:0] len; } aw_t;
    typedef struct packed { logic [DW-1:0] data; logic last; } w_t;
    typedef struct {
        logic [AW-1:0] base; int size;
        int aw_pct; int w_pct; int t_pct; int b_pct;
        int exp_aw; int exp_w; int exp_len;
    } vec_t;

    aw_t           got_aw[$];
    w_t            got_w[$];
    logic [DW-1:0] src[$];
    vec_t          vt[5];

    int checks = 0, errors = 0, cyc = 0;
    int aw_pct, w_pct, t_pct, b_pct, b_budget;
    bit start_req, rst_req;
    int src_idx, aw_tot, wlast_tot, b_tot, done_cnt, done_cyc, start_cyc, last_b_cyc;
    int max_out, tready_seen;
    bit hs_aw, hs_w, hs_t, hs_b, aw_wait;
    aw_t aw_held;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkw(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit roll(int pct);
        return int'($urandom_range(0, 99)) < pct;
    endfunction

    // One clock: drive inputs just after the rising edge, then sample at the falling edge
    task automatic cycle();
        int pend;
        @(posedge clk); #1;
        rst = rst_req;          rst_req = 1'b0;
        ctrl_start = start_req; start_req = 1'b0;
        m_axi_awready = roll(aw_pct);
        m_axi_wready  = roll(w_pct);
        if (!s_axis_tvalid || hs_t) begin
            s_axis_tvalid = (src_idx < src.size()) && roll(t_pct);
            if (src_idx < src.size()) s_axis_tdata = src[src_idx];
        end
        if (!m_axi_bvalid || hs_b) begin
            pend = ((aw_tot < wlast_tot) ? aw_tot : wlast_tot) - b_tot;
            m_axi_bvalid = (pend > 0) && (b_budget != 0) && roll(b_pct);
        end
        if (rst) begin
            s_axis_tvalid = 1'b0;
            m_axi_bvalid  = 1'b0;
        end
        @(negedge clk);
        cyc++;
        hs_aw = m_axi_awvalid && m_axi_awready;
        hs_w  = m_axi_wvalid && m_axi_wready;
        hs_t  = s_axis_tvalid && s_axis_tready;
        hs_b  = m_axi_bvalid && m_axi_bready;
        if (aw_wait && !rst) begin
            chk("aw_hold_valid", 64'(m_axi_awvalid), 64'd1);
            chk("aw_hold_addr_len", 64'({m_axi_awaddr[55:0], m_axi_awlen}),
                64'({aw_held.addr[55:0], aw_held.len}));
        end
        aw_wait = m_axi_awvalid && !m_axi_awready && !rst;
        aw_held = '{addr: m_axi_awaddr, len: m_axi_awlen};
        if (hs_aw) begin
            got_aw.push_back(aw_held);
            aw_tot++;
            if (aw_tot - b_tot > max_out) max_out = aw_tot - b_tot;
        end
        if (hs_w || hs_t) chk("w_passthru_hs", 64'(hs_w), 64'(hs_t));
        if (hs_w) begin
            got_w.push_back('{data: m_axi_wdata, last: m_axi_wlast});
            if (m_axi_wlast) wlast_tot++;
        end
        if (hs_t) src_idx++;
        if (s_axis_tready) tready_seen++;
        if (hs_b) begin
            b_tot++;
            last_b_cyc = cyc;
            if (b_budget > 0) b_budget--;
        end
        if (ctrl_done) begin done_cnt++; done_cyc = cyc; end
        if (ctrl_start) start_cyc = cyc;
    endtask

    task automatic env_clear();
        got_aw.delete(); got_w.delete(); src.delete();
        src_idx = 0; aw_tot = 0; wlast_tot = 0; b_tot = 0; done_cnt = 0;
        done_cyc = -1; start_cyc = -1; last_b_cyc = -1; max_out = 0; tready_seen = 0;
        aw_wait = 1'b0; hs_t = 1'b0; hs_b = 1'b0;
        s_axis_tvalid = 1'b0; m_axi_bvalid = 1'b0;
    endtask

    task automatic set_rates(int a, int w, int t, int b);
        aw_pct = a; w_pct = w; t_pct = t; b_pct = b; b_budget = -1;
    endtask

    task automatic begin_xfer(logic [AW-1:0] base, int size);
        env_clear();
        for (int i = 0; i < size / BPB + 3; i++)
            src.push_back({16{$urandom}});
        ctrl_addr_offset = base;
        ctrl_xfer_size_in_bytes = XW'(size);
        start_req = 1'b1;
    endtask

    task automatic wait_done(string tag);
        int n = 0;
        while (done_cnt == 0 && n < 8000) begin cycle(); n++; end
        chk({tag, " done_seen"}, 64'(done_cnt > 0), 64'd1);
        repeat (5) cycle();
    endtask

    // Reference: bursts of BL beats at 4 KB strides, the last one carrying the remainder
    task automatic check_model(logic [AW-1:0] base, int size, string tag);
        int tb_, nb;
        logic [AW-1:0] ea;
        logic [7:0] el;
        tb_ = size / BPB;
        nb  = (tb_ + BL - 1) / BL;
        chk({tag, " aw_count"}, 64'(got_aw.size()), 64'(nb));
        for (int i = 0; i < got_aw.size() && i < nb; i++) begin
            ea = base + 64'(i) * 64'(BL * BPB);
            el = (i == nb - 1) ? 8'(tb_ - BL * (nb - 1) - 1) : 8'(BL - 1);
            chk($sformatf("%s aw%0d addr", tag, i), got_aw[i].addr, ea);
            chk($sformatf("%s aw%0d len", tag, i), 64'(got_aw[i].len), 64'(el));
        end
        chk({tag, " w_count"}, 64'(got_w.size()), 64'(tb_));
        for (int i = 0; i < got_w.size() && i < tb_ && i < src.size(); i++) begin
            chkw($sformatf("%s w%0d data", tag, i), got_w[i].data, src[i]);
            chk($sformatf("%s w%0d last", tag, i), 64'(got_w[i].last),
                64'(((i % BL) == BL - 1) || (i == tb_ - 1)));
        end
        chk({tag, " consumed"}, 64'(src_idx), 64'(tb_));
        chk({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
        chk({tag, " b_count"}, 64'(b_tot), 64'(nb));
        chk({tag, " over_credit"}, 64'(max_out > MO), 64'd0);
        if (nb > 0) chk({tag, " done_after_b"}, 64'(done_cyc), 64'(last_b_cyc + 1));
        else        chk({tag, " done_after_start"}, 64'(done_cyc), 64'(start_cyc + 1));
    endtask

    initial begin
        int n;
        logic [AW-1:0] base;
        vt[0] = '{64'h1000, 64,   100, 100, 100, 100, 1, 1,   0};
        vt[1] = '{64'h0,    8256, 100, 100, 100, 100, 3, 129, 0};
        vt[2] = '{64'h3000, 8192, 70,  60,  80,  50,  2, 128, 63};
        vt[3] = '{64'h7000, 640,  50,  100, 50,  100, 1, 10,  9};
        vt[4] = '{64'h9000, 0,    100, 100, 100, 100, 0, 0,   0};

        rst = 1'b1; ctrl_start = 1'b0; ctrl_addr_offset = '0; ctrl_xfer_size_in_bytes = '0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0;
        start_req = 1'b0; rst_req = 1'b1;
        set_rates(100, 100, 100, 100);
        env_clear();

        cycle();
        chk("rst awvalid", 64'(m_axi_awvalid), 64'd0);
        chk("rst wvalid",  64'(m_axi_wvalid),  64'd0);
        chk("rst bready",  64'(m_axi_bready),  64'd0);
        chk("rst tready",  64'(s_axis_tready), 64'd0);
        chk("rst done",    64'(ctrl_done),     64'd0);
        chk("wstrb ones",  64'(&m_axi_wstrb),  64'd1);
        cycle();

        for (int v = 0; v < 5; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            set_rates(vt[v].aw_pct, vt[v].w_pct, vt[v].t_pct, vt[v].b_pct);
            begin_xfer(vt[v].base, vt[v].size);
            wait_done(tag);
            chk({tag, " tbl_aw"}, 64'(got_aw.size()), 64'(vt[v].exp_aw));
            chk({tag, " tbl_w"},  64'(got_w.size()),  64'(vt[v].exp_w));
            if (vt[v].exp_aw > 0 && got_aw.size() > 0)
                chk({tag, " tbl_last_len"}, 64'(got_aw[got_aw.size()-1].len), 64'(vt[v].exp_len));
            if (vt[v].size == 0)
                chk({tag, " no_tready"}, 64'(tready_seen), 64'd0);
            check_model(vt[v].base, vt[v].size, tag);
        end

        // Credit limit: B withheld, only MO bursts may be issued
        set_rates(100, 100, 100, 100);
        b_budget = 0;
        begin_xfer(64'h10000, 4 * BL * BPB);
        repeat (300) cycle();
        chk("credit aw_issued", 64'(aw_tot), 64'(MO));
        chk("credit awvalid_low", 64'(m_axi_awvalid), 64'd0);
        chk("credit w_beats", 64'(got_w.size()), 64'(MO * BL));
        b_budget = 1;
        repeat (20) cycle();
        chk("credit aw_after_b1", 64'(aw_tot), 64'(MO + 1));
        b_budget = 1;
        repeat (20) cycle();
        chk("credit aw_after_b2", 64'(aw_tot), 64'(MO + 2));
        chk("credit no_early_done", 64'(done_cnt), 64'd0);
        b_budget = -1;
        wait_done("credit");
        check_model(64'h10000, 4 * BL * BPB, "credit");

        // Simultaneous AW and B handshakes leave the credit count unchanged
        set_rates(100, 100, 100, 0);
        begin_xfer(64'h20000, 3 * BL * BPB);
        n = 0;
        while (aw_tot < 1 && n < 50) begin cycle(); n++; end
        aw_pct = 0;
        n = 0;
        while (wlast_tot < 1 && n < 400) begin cycle(); n++; end
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("simul stall_valid", 64'(m_axi_awvalid), 64'd1);
            chk("simul stall_addr", m_axi_awaddr, 64'h21000);
        end
        aw_pct = 100; b_pct = 100;
        cycle();
        chk("simul both_hs", 64'({hs_aw, hs_b}), 64'd3);
        cycle();
        chk("simul next_aw_valid", 64'(m_axi_awvalid), 64'd1);
        chk("simul next_aw_addr", m_axi_awaddr, 64'h22000);
        wait_done("simul");
        check_model(64'h20000, 3 * BL * BPB, "simul");

        // Start while busy is ignored
        set_rates(100, 100, 100, 0);
        begin_xfer(64'h30000, 2 * BPB);
        repeat (20) cycle();
        ctrl_addr_offset = 64'h40000;
        ctrl_xfer_size_in_bytes = XW'(BPB);
        start_req = 1'b1;
        repeat (5) cycle();
        b_pct = 100;
        wait_done("busy_start");
        check_model(64'h30000, 2 * BPB, "busy_start");

        // Reset mid-burst, then a clean transfer
        set_rates(100, 100, 100, 100);
        begin_xfer(64'h50000, 2 * BL * BPB);
        n = 0;
        while (got_w.size() < 10 && n < 100) begin cycle(); n++; end
        rst_req = 1'b1;
        cycle();
        cycle();
        chk("mrst awvalid", 64'(m_axi_awvalid), 64'd0);
        chk("mrst wvalid",  64'(m_axi_wvalid),  64'd0);
        chk("mrst bready",  64'(m_axi_bready),  64'd0);
        chk("mrst tready",  64'(s_axis_tready), 64'd0);
        chk("mrst done",    64'(ctrl_done),     64'd0);
        repeat (5) cycle();
        chk("mrst no_done", 64'(done_cnt), 64'd0);
        begin_xfer(64'h60000, 65 * BPB);
        wait_done("post_rst");
        check_model(64'h60000, 65 * BPB, "post_rst");

        // Randomized transfers against the reference model
        for (int r = 0; r < 8; r++) begin
            string tag;
            int beats;
            tag = $sformatf("rand%0d", r);
            beats = int'($urandom_range(1, 300));
            base = 64'($urandom_range(0, 1023)) << 12;
            set_rates(int'($urandom_range(40, 100)), int'($urandom_range(40, 100)),
                      int'($urandom_range(40, 100)), int'($urandom_range(40, 100)));
            begin_xfer(base, beats * BPB);
            wait_done(tag);
            check_model(base, beats * BPB, tag);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/byteswap_axi_write_ctrl.md
Name: byteswap_axi_write_ctrl

Overview:
AXI4 write-master controller for the byteswap kernel's output side. It takes a base address and byte count, splits the transfer into fixed-length INCR bursts and forwards an AXI4-Stream of swapped data onto the W channel with correct WLAST. It tracks outstanding bursts against a credit limit and pulses done once every B response has returned. It is the write-side counterpart of the kernel's read master and feeds the m_axi write port.

Parameters:
C_ADDR_WIDTH, 64, AXI address width
C_DATA_WIDTH, 512, AXI/stream data width in bits (power of 2, >=32)
C_XFER_SIZE_WIDTH, 32, width of the byte-count input
C_BURST_LEN, 64, beats per full burst (1..256; C_BURST_LEN*C_DATA_WIDTH/8 <= 4096)
C_MAX_OUTSTANDING, 16, maximum AW bursts issued without B response (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ctrl_start  in  1  single-cycle start request
ctrl_done  out  1  single-cycle pulse, transfer complete
ctrl_addr_offset  in  C_ADDR_WIDTH  base byte address, 4 KB aligned
ctrl_xfer_size_in_bytes  in  C_XFER_SIZE_WIDTH  total bytes, multiple of C_DATA_WIDTH/8
m_axi_awvalid  out  1  AW valid
m_axi_awready  in  1  AW ready
m_axi_awaddr  out  C_ADDR_WIDTH  burst address
m_axi_awlen  out  8  beats-1
m_axi_wvalid  out  1  W valid
m_axi_wready  in  1  W ready
m_axi_wdata  out  C_DATA_WIDTH  write data
m_axi_wstrb  out  C_DATA_WIDTH/8  all ones
m_axi_wlast  out  1  last beat of burst
m_axi_bvalid  in  1  B valid
m_axi_bready  out  1  B ready
s_axis_tvalid  in  1  input stream valid
s_axis_tready  out  1  input stream ready
s_axis_tdata  in  C_DATA_WIDTH  input stream data

Behaviour:
- States IDLE, BUSY, DONE. Reset: state IDLE; ctrl_done, awvalid, wvalid, bready, s_axis_tready all 0; all counters 0.
- IDLE: ctrl_start=1 latches addr/size; total_beats = size/(C_DATA_WIDTH/8); num_bursts = ceil(total_beats/C_BURST_LEN); final burst length = remainder, or C_BURST_LEN if remainder is 0. Next state BUSY; if size==0, next state DONE directly.
- ctrl_start outside IDLE is ignored.
- AW: awvalid=1 while aw_remaining>0 and outstanding<C_MAX_OUTSTANDING. awaddr/awlen are held stable while awvalid && !awready.
- Burst n: awaddr = base + n*C_BURST_LEN*bytes_per_beat; awlen = C_BURST_LEN-1, last burst = final-1.
- Outstanding counter: +1 on AW handshake, -1 on B handshake, unchanged if both occur in the same cycle or neither occurs. It never exceeds C_MAX_OUTSTANDING and never underflows.
- W: bursts are gated so W bursts started <= AW bursts accepted. While gated open, wvalid = s_axis_tvalid, s_axis_tready = m_axi_wready, wdata = tdata (combinational pass-through, zero latency).
- wlast=1 on beat index = burst length-1. The beat counter resets at each wlast handshake.
- No stream data is consumed beyond total_beats.
- bready=1 in BUSY. The B-remaining counter decrements per B handshake; BRESP is ignored.
- BUSY->DONE when the last B handshake occurs and all W beats are sent. DONE asserts ctrl_done for exactly one cycle, then goes to IDLE.
- Next ctrl_start is accepted the cycle after the done pulse.
- rst at any time: immediate return to reset state. In-flight AXI transactions are abandoned; the system resets the interconnect with the kernel.

Test Plan:
- Single beat: base 0x1000, size 64 -> one AW (addr 0x1000, awlen 0), one W with wlast=1, B -> ctrl_done pulse exactly one cycle after the B handshake.
- Multi-burst: base 0x0, size 8256 -> AWs at 0x0/0x1000/0x2000 with awlen 63/63/0; wlast on beats 63, 127 and 128; one done pulse.
- Credit limit: C_MAX_OUTSTANDING=2, bvalid held 0, size 4 bursts -> exactly 2 AWs issued, awvalid drops. Each B releases one more AW; done only after 4 Bs.
- Simultaneous: AW and B handshakes in the same cycle -> outstanding count unchanged; awvalid/awaddr stable under awready=0 backpressure for 5 cycles.
- Zero size: start with size 0 -> ctrl_done one cycle later; no AW, W or s_axis_tready activity; start during BUSY ignored.
- Reset mid-burst after 10 beats -> next cycle all valids/ready 0 and no ctrl_done. A new start then runs a clean transfer from burst 0.
